// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin arbiter that shares the register-file write
// port among NUM_REQ writeback sources through a one-entry output stage.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_rd/req_data  per-source write offers (packed slices)
//   req_ready                one-hot-or-zero grant, transfer on valid&ready
//   rf_hold                  freezes the output stage (no write while high)
//   rf_we/rf_rd/rf_wdata     register-file write port
//   wb_busy                  bit r set while a write to r is pending
//   grant_cnt                total accepted requests, wraps at 2^16
module rf_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_rd,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      rf_hold,
    output logic                      rf_we,
    output logic [ADDR_W-1:0]         rf_rd,
    output logic [DATA_W-1:0]         rf_wdata,
    output logic [31:0]               wb_busy,
    output logic [15:0]               grant_cnt
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  ptr_nxt;
    logic [PTR_W-1:0]  win_idx;
    logic              win_found;
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;
    logic              slot_free;
    logic              grant;

    logic              out_valid;
    logic [ADDR_W-1:0] out_rd;
    logic [DATA_W-1:0] out_wdata;

    // Search ptr, ptr+1, ... wrapping at NUM_REQ; first valid source wins.
    always_comb begin : arb
        int j;
        j         = 0;
        win_found = 1'b0;
        win_idx   = '0;
        sel_rd    = '0;
        sel_data  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!win_found && req_valid[j]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(j);
                sel_rd    = req_rd[j*ADDR_W +: ADDR_W];
                sel_data  = req_data[j*DATA_W +: DATA_W];
            end
        end
    end

    assign ptr_nxt = (win_idx == PTR_W'(NUM_REQ - 1))
                   ? '0
                   : win_idx + 1'b1;

    // The slot drains whenever hold is low, so a held entry and a new
    // grant can pass through in the same cycle.
    assign slot_free = ~out_valid | ~rf_hold;
    assign grant     = slot_free & win_found & ~rst;

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            out_valid <= 1'b0;
            out_rd    <= '0;
            out_wdata <= '0;
            grant_cnt <= '0;
        end else if (slot_free) begin
            if (grant) begin
                // x0 writes are consumed but never reach the file.
                out_valid <= (sel_rd != '0);
                out_rd    <= sel_rd;
                out_wdata <= sel_data;
                ptr       <= ptr_nxt;
                grant_cnt <= grant_cnt + 16'd1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    assign rf_we    = out_valid & ~rf_hold;
    assign rf_rd    = out_rd;
    assign rf_wdata = out_wdata;

    always_comb begin
        wb_busy = '0;
        for (int r = 1; r < 32; r++) begin
            wb_busy[r] = out_valid & (32'(out_rd) == 32'(r));
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed and randomized checks of rf_wb_arbiter
// against a cycle-level reference model of the arbitration rules.
module tb_rf_wb_arbiter;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N*AW-1:0] req_rd;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  req_ready;
    logic          rf_hold;
    logic          rf_we;
    logic [AW-1:0] rf_rd;
    logic [DW-1:0] rf_wdata;
    logic [31:0]   wb_busy;
    logic [15:0]   grant_cnt;

    logic [AW-1:0] src_rd [N];
    logic [DW-1:0] src_data [N];

    always #5 clk = ~clk;

    always_comb begin
        req_rd   = '0;
        req_data = '0;
        for (int i = 0; i < N; i++) begin
            req_rd[i*AW +: AW]   = src_rd[i];
            req_data[i*DW +: DW] = src_data[i];
        end
    end

    rf_wb_arbiter #(
        .NUM_REQ(N),
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_rd   (req_rd),
        .req_data (req_data),
        .req_ready(req_ready),
        .rf_hold  (rf_hold),
        .rf_we    (rf_we),
        .rf_rd    (rf_rd),
        .rf_wdata (rf_wdata),
        .wb_busy  (wb_busy),
        .grant_cnt(grant_cnt)
    );

    int            n_tests = 0;
    int            n_fail  = 0;

    int            m_ptr;
    bit            m_valid;
    logic [AW-1:0] m_rd;
    logic [DW-1:0] m_data;
    int            m_cnt;
    bit            m_fresh;
    int            last_w;

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: called at a negedge with inputs driven; checks outputs
    // against the model, advances the model at the posedge, and returns
    // at the following negedge.
    task automatic step(input bit chk);
        int            w;
        int            j;
        bit            free;
        logic [N-1:0]  er;
        logic [63:0]   eb;
        #1;
        free = !m_valid || !rf_hold;
        w    = -1;
        if (free && !rst) begin
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (w < 0 && req_valid[j]) w = j;
            end
        end
        er = '0;
        if (w >= 0) er[w] = 1'b1;
        eb = m_valid ? (64'd1 << m_rd) : 64'd0;
        if (chk) begin
            check("req_ready", 64'(req_ready), 64'(er));
            check("rf_we", 64'(rf_we), 64'(m_valid && !rf_hold));
            if (m_valid || m_fresh) begin
                check("rf_rd", 64'(rf_rd), 64'(m_rd));
                check("rf_wdata", 64'(rf_wdata), 64'(m_data));
            end
            check("wb_busy", 64'(wb_busy), eb);
            check("grant_cnt", 64'(grant_cnt), 64'(m_cnt));
        end
        @(posedge clk);
        if (rst) begin
            m_ptr   = 0;
            m_valid = 0;
            m_rd    = '0;
            m_data  = '0;
            m_cnt   = 0;
            m_fresh = 1;
        end else if (free) begin
            if (w >= 0) begin
                m_valid = (src_rd[w] != 0);
                m_rd    = src_rd[w];
                m_data  = src_data[w];
                m_ptr   = (w + 1) % N;
                m_cnt   = (m_cnt + 1) % 65536;
                m_fresh = 0;
            end else begin
                m_valid = 0;
            end
        end
        last_w = w;
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        rf_hold   = 1'b0;
        req_valid = '0;
        for (int i = 0; i < N; i++) begin
            src_rd[i]   = '0;
            src_data[i] = '0;
        end
        m_ptr = 0; m_valid = 0; m_rd = '0; m_data = '0;
        m_cnt = 0; m_fresh = 1; last_w = -1;

        @(negedge clk);
        step(0);
        step(1);
        rst = 1'b0;
        repeat (5) step(1);

        // single request from source 1
        src_rd[1]   = 5'd7;
        src_data[1] = 32'hDEADBEEF;
        req_valid   = 3'b010;
        step(1);
        req_valid = '0;
        step(1);
        step(1);

        // continuous round robin from ptr 0
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            src_rd[i]   = AW'(i + 1);
            src_data[i] = 32'h1000 + i;
        end
        req_valid = '1;
        repeat (6) step(1);
        req_valid = '0;
        step(1);
        check("rr_cnt6", 64'(grant_cnt), 64'd6);

        // rd == 0 request
        src_rd[0]   = '0;
        src_data[0] = 32'h55;
        req_valid   = 3'b001;
        step(1);
        req_valid = '0;
        step(1);

        // hold with a pending write to x3
        src_rd[m_ptr]   = 5'd3;
        src_data[m_ptr] = 32'hCAFE0003;
        req_valid       = '0;
        req_valid[m_ptr] = 1'b1;
        step(1);
        for (int i = 0; i < N; i++) begin
            src_rd[i]   = AW'(i + 4);
            src_data[i] = 32'hB000 + i;
        end
        req_valid = '1;
        rf_hold   = 1'b1;
        repeat (4) step(1);
        rf_hold = 1'b0;
        step(1);
        req_valid = '0;
        step(1);

        // reset while an entry is held
        req_valid = '1;
        step(1);
        rf_hold = 1'b1;
        step(1);
        rst = 1'b1;
        step(1);
        rst     = 1'b0;
        rf_hold = 1'b0;
        step(1);
        check("post_rst_win", 64'(last_w), 64'd0);
        req_valid = '0;
        step(1);

        // randomized traffic; sources hold their offer until granted
        for (int c = 0; c < 3000; c++) begin
            rst     = ($urandom_range(99) < 2);
            rf_hold = ($urandom_range(3) == 0);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(1) == 1) begin
                    req_valid[i] = 1'b1;
                    src_rd[i]    = ($urandom_range(7) == 0)
                                 ? '0 : AW'($urandom_range(31, 1));
                    src_data[i]  = $urandom;
                end
            end
            step(1);
            if (last_w >= 0) req_valid[last_w] = 1'b0;
        end

        // grant counter wrap
        rst     = 1'b1;
        rf_hold = 1'b0;
        step(1);
        rst       = 1'b0;
        req_valid = '1;
        repeat (65535) step(0);
        check("cnt_ffff", 64'(grant_cnt), 64'hFFFF);
        step(1);
        req_valid = '0;
        step(1);
        check("cnt_wrap", 64'(grant_cnt), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
